// File: rtl/ssp_tx_fifo.sv
// ssp_tx_fifo
// Transmit FIFO feeding the SSP serializer. The processor pushes words with
// PSEL & PWRITE; the serializer pops with a one-cycle NEXT_WORD strobe and
// sees the head word on TxData (first-word-fall-through).
//
// Ports:
//   PCLK       system clock, rising edge
//   CLEAR_B    asynchronous active-low reset (clears pointers, count, storage)
//   PSEL       peripheral select
//   PWRITE     write qualifier; push requested when PSEL & PWRITE
//   PWDATA     write data
//   NEXT_WORD  pop strobe from serializer
//   TxData     head-of-queue word, combinational read of mem[rd_ptr]
//   TX_VALID   FIFO not empty
//   SSPTXINTR  FIFO full
//   TX_OVF     sticky dropped-write flag (only with SSP_TXFIFO_OVERFLOW_EN)
//   OVF_CLR    clears TX_OVF
//
// Build option:
//   SSP_TXFIFO_OVERFLOW_EN  when defined, synthesizes the TX_OVF sticky
//                           register; otherwise TX_OVF is 0 and OVF_CLR is
//                           ignored.

module ssp_tx_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int ADDR_BITS = 2
) (
  input  logic             PCLK,
  input  logic             CLEAR_B,
  input  logic             PSEL,
  input  logic             PWRITE,
  input  logic [WIDTH-1:0] PWDATA,
  input  logic             NEXT_WORD,
  output logic [WIDTH-1:0] TxData,
  output logic             TX_VALID,
  output logic             SSPTXINTR,
  output logic             TX_OVF,
  input  logic             OVF_CLR
);

  localparam logic [ADDR_BITS:0] FULL_CNT = (ADDR_BITS+1)'(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS:0]   count;

  logic push_req;
  logic pop_req;
  logic push_ok;
  logic pop_ok;

  assign push_req = PSEL & PWRITE;
  assign pop_req  = NEXT_WORD;

  // A full FIFO still accepts a push when a pop frees the head slot in the
  // same cycle; the write lands in the slot the pop is vacating.
  assign pop_ok  = pop_req & (count != '0);
  assign push_ok = push_req & ((count != FULL_CNT) | pop_ok);

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= PWDATA;
        wr_ptr      <= wr_ptr + ADDR_BITS'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + ADDR_BITS'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (ADDR_BITS+1)'(1);
        2'b01:   count <= count - (ADDR_BITS+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign TxData    = mem[rd_ptr];
  assign TX_VALID  = (count != '0);
  assign SSPTXINTR = (count == FULL_CNT);

`ifdef SSP_TXFIFO_OVERFLOW_EN
  logic ovf_q;

  // A dropped write in the same cycle as OVF_CLR keeps the flag set.
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      ovf_q <= 1'b0;
    end else if (push_req & ~push_ok) begin
      ovf_q <= 1'b1;
    end else if (OVF_CLR) begin
      ovf_q <= 1'b0;
    end
  end

  assign TX_OVF = ovf_q;
`else
  logic ovf_clr_unused;

  assign ovf_clr_unused = OVF_CLR;
  assign TX_OVF         = 1'b0;
`endif

endmodule

// File: tb/tb_ssp_tx_fifo.sv
// Bench for ssp_tx_fifo: table of per-cycle vectors with hand-computed
// expected outputs, followed by hand-written reset sequences.

module tb_ssp_tx_fifo;

`ifdef SSP_TXFIFO_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       PCLK;
  logic       CLEAR_B;
  logic       PSEL;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic       NEXT_WORD;
  logic [7:0] TxData;
  logic       TX_VALID;
  logic       SSPTXINTR;
  logic       TX_OVF;
  logic       OVF_CLR;

  int total;
  int bad;

  ssp_tx_fifo #(.WIDTH(8), .DEPTH(4), .ADDR_BITS(2)) dut (
    .PCLK      (PCLK),
    .CLEAR_B   (CLEAR_B),
    .PSEL      (PSEL),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .NEXT_WORD (NEXT_WORD),
    .TxData    (TxData),
    .TX_VALID  (TX_VALID),
    .SSPTXINTR (SSPTXINTR),
    .TX_OVF    (TX_OVF),
    .OVF_CLR   (OVF_CLR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic       psel;
    logic       pwrite;
    logic [7:0] pwdata;
    logic       next_word;
    logic       ovf_clr;
    logic       exp_valid;
    logic       exp_intr;
    logic [7:0] exp_data;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [28];

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, actual, expected);
    end
  endtask

  task automatic check_outputs(input string tag, input logic v, input logic i,
                               input logic [7:0] d, input logic o);
    check({tag, " TX_VALID"}, int'(TX_VALID), int'(v));
    check({tag, " SSPTXINTR"}, int'(SSPTXINTR), int'(i));
    check({tag, " TxData"}, int'(TxData), int'(d));
    check({tag, " TX_OVF"}, int'(TX_OVF), int'(o));
  endtask

  task automatic drive(input logic ps, input logic pw, input logic [7:0] pd,
                       input logic nw, input logic oc);
    PSEL      = ps;
    PWRITE    = pw;
    PWDATA    = pd;
    NEXT_WORD = nw;
    OVF_CLR   = oc;
  endtask

  task automatic cycle();
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    //           ps pw data  nw oc | valid intr data  ovf
    vecs[0]  = '{0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0};       // idle after reset
    vecs[1]  = '{1, 1, 8'hA5, 0, 0, 1, 0, 8'hA5, 0};       // single word
    vecs[2]  = '{0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0};       // pop -> empty
    vecs[3]  = '{0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0};       // pop when empty
    vecs[4]  = '{1, 1, 8'h11, 1, 0, 1, 0, 8'h11, 0};       // push+pop when empty
    vecs[5]  = '{1, 1, 8'h22, 0, 0, 1, 0, 8'h11, 0};
    vecs[6]  = '{1, 1, 8'h33, 0, 0, 1, 0, 8'h11, 0};
    vecs[7]  = '{1, 1, 8'h44, 0, 0, 1, 1, 8'h11, 0};       // full, wr wraps
    vecs[8]  = '{1, 1, 8'h99, 0, 0, 1, 1, 8'h11, OVF_EN};  // dropped write
    vecs[9]  = '{0, 0, 8'h00, 0, 0, 1, 1, 8'h11, OVF_EN};  // flag holds
    vecs[10] = '{1, 1, 8'h55, 1, 0, 1, 1, 8'h22, OVF_EN};  // full push+pop
    vecs[11] = '{0, 0, 8'h00, 0, 1, 1, 1, 8'h22, 0};       // clear flag
    vecs[12] = '{0, 0, 8'h00, 1, 0, 1, 0, 8'h33, 0};
    vecs[13] = '{0, 0, 8'h00, 1, 0, 1, 0, 8'h44, 0};       // rd wraps
    vecs[14] = '{0, 0, 8'h00, 1, 0, 1, 0, 8'h55, 0};
    vecs[15] = '{0, 0, 8'h00, 1, 0, 0, 0, 8'h22, 0};       // empty, stale data
    vecs[16] = '{0, 0, 8'h00, 1, 0, 0, 0, 8'h22, 0};       // pop when empty
    vecs[17] = '{1, 1, 8'h01, 0, 0, 1, 0, 8'h01, 0};
    vecs[18] = '{1, 1, 8'h02, 0, 0, 1, 0, 8'h01, 0};
    vecs[19] = '{1, 1, 8'h03, 0, 0, 1, 0, 8'h01, 0};
    vecs[20] = '{1, 1, 8'h04, 0, 0, 1, 1, 8'h01, 0};
    vecs[21] = '{1, 1, 8'h66, 0, 1, 1, 1, 8'h01, OVF_EN};  // set beats clear
    vecs[22] = '{0, 0, 8'h00, 0, 1, 1, 1, 8'h01, 0};
    vecs[23] = '{1, 0, 8'hBB, 1, 0, 1, 0, 8'h02, 0};       // read strobe only pops
    vecs[24] = '{0, 1, 8'hAA, 0, 0, 1, 0, 8'h02, 0};       // PWRITE w/o PSEL
    vecs[25] = '{0, 0, 8'h00, 1, 0, 1, 0, 8'h03, 0};
    vecs[26] = '{0, 0, 8'h00, 1, 0, 1, 0, 8'h04, 0};
    vecs[27] = '{0, 0, 8'h00, 1, 0, 0, 0, 8'h01, 0};       // empty, stale data

    drive(0, 0, 8'h00, 0, 0);
    CLEAR_B = 1'b0;
    cycle();
    cycle();
    check_outputs("reset_held", 0, 0, 8'h00, 0);
    @(negedge PCLK);
    CLEAR_B = 1'b1;
    cycle();
    check_outputs("reset_release", 0, 0, 8'h00, 0);

    for (int k = 0; k < 28; k++) begin
      drive(vecs[k].psel, vecs[k].pwrite, vecs[k].pwdata,
            vecs[k].next_word, vecs[k].ovf_clr);
      cycle();
      check_outputs($sformatf("vec%0d", k), vecs[k].exp_valid, vecs[k].exp_intr,
                    vecs[k].exp_data, vecs[k].exp_ovf);
    end

    // Async reset with three words queued; the head slot is not mem[0], and
    // mem[0] holds a queued word, so a cleared array shows up as TxData = 0.
    drive(1, 1, 8'hC1, 0, 0);
    cycle();
    drive(1, 1, 8'hC2, 0, 0);
    cycle();
    drive(1, 1, 8'hC3, 0, 0);
    cycle();
    drive(0, 0, 8'h00, 0, 0);
    check_outputs("queued3", 1, 0, 8'hC1, 0);
    @(negedge PCLK);
    CLEAR_B = 1'b0;
    #1;
    check_outputs("async_reset", 0, 0, 8'h00, 0);
    @(negedge PCLK);
    CLEAR_B = 1'b1;
    cycle();
    check_outputs("after_reset", 0, 0, 8'h00, 0);
    drive(1, 1, 8'h7E, 0, 0);
    cycle();
    drive(0, 0, 8'h00, 0, 0);
    check_outputs("push_7e", 1, 0, 8'h7E, 0);

    // Async reset clears a set overflow flag (only reachable with the option).
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 8'(8'hD0 + k), 0, 0);
      cycle();
    end
    check_outputs("refill", 1, 1, 8'h7E, OVF_EN);
    drive(0, 0, 8'h00, 0, 0);
    @(negedge PCLK);
    CLEAR_B = 1'b0;
    #1;
    check_outputs("reset_ovf", 0, 0, 8'h00, 0);
    @(negedge PCLK);
    CLEAR_B = 1'b1;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ssp_tx_fifo.md
Name: ssp_tx_fifo

Overview:
Transmit FIFO that sits directly upstream of the SSP serializer core (ssp_tx_rx). The processor side writes bytes via APB-style PSEL/PWRITE/PWDATA strobes. The serializer pops bytes with a one-cycle NEXT_WORD strobe and sees the head byte on TxData as first-word-fall-through. SSPTXINTR reports FIFO full to the interrupt logic.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 4, number of entries; must be a power of two >= 2
ADDR_BITS, 2, log2(DEPTH); pointer width

Ports:
PCLK  input  1  system clock; all state changes on rising edge
CLEAR_B  input  1  asynchronous active-low reset
PSEL  input  1  peripheral select from bus
PWRITE  input  1  write qualifier; a push is requested when PSEL & PWRITE
PWDATA  input  WIDTH  write data
NEXT_WORD  input  1  pop strobe from serializer, one PCLK cycle per byte consumed
TxData  output  WIDTH  head-of-queue word (mem[rd_ptr])
TX_VALID  output  1  FIFO not empty; TxData is meaningful
SSPTXINTR  output  1  FIFO full (count == DEPTH)
TX_OVF  output  1  sticky overflow flag (see Optional Feature)
OVF_CLR  input  1  clears TX_OVF

Behaviour:
- Reset:
  - Assertion of CLEAR_B at any time, including mid-push or mid-pop, asynchronously sets wr_ptr = 0, rd_ptr = 0, count = 0 and all storage entries = 0.
  - While reset is held and on release: TxData = 0, TX_VALID = 0, SSPTXINTR = 0, TX_OVF = 0.
- State:
  - wr_ptr and rd_ptr, each ADDR_BITS wide, wrap modulo DEPTH.
  - count, ADDR_BITS+1 bits wide, range 0..DEPTH.
  - Storage array of DEPTH x WIDTH.
- push_req = PSEL & PWRITE. pop_req = NEXT_WORD.
- Accepted operations, evaluated against registered count at the clock edge:
  - pop_ok = pop_req & (count != 0).
  - push_ok = push_req & ((count != DEPTH) | pop_ok). A push into a full FIFO is accepted when a pop occurs in the same cycle.
- Edge actions:
  - push_ok: mem[wr_ptr] <= PWDATA; wr_ptr <= wr_ptr + 1.
  - pop_ok: rd_ptr <= rd_ptr + 1.
  - count <= count + push_ok - pop_ok.
  - Simultaneous push and pop leaves count unchanged.
- Outputs, all derived from registered state only:
  - TX_VALID = (count != 0).
  - SSPTXINTR = (count == DEPTH).
  - TxData = mem[rd_ptr], combinational read.
- Latency:
  - A word written at edge N appears on TxData, with TX_VALID = 1, after edge N when the FIFO was empty.
  - After a pop at edge N, the next word is on TxData after edge N.
- Boundary conditions:
  - Pop when empty: ignored; pointers and count unchanged; TxData keeps its prior (stale) value.
  - Push when full without pop: word dropped; storage unchanged.
  - Pointer wrap: DEPTH-1 -> 0 with no bubble.
  - Push and pop in the same cycle when empty: the push is accepted and the pop is ignored; count becomes 1.
- No internal FSM beyond the count register; there is no handshake back to the writer. Software is expected to poll or use SSPTXINTR before writing.

Optional Feature:
Macro: SSP_TXFIFO_OVERFLOW_EN.
- Defined:
  - TX_OVF is set on the edge where push_req & !push_ok occurs, i.e. a dropped write.
  - TX_OVF holds until an edge with OVF_CLR = 1 and no simultaneous dropped write; a set in the same cycle wins over the clear.
  - Cleared by reset.
- Undefined:
  - TX_OVF is tied to 0 and OVF_CLR is ignored.
  - No overflow register is synthesized.
  - All other behaviour is identical.

Test Plan:
- Reset then idle: hold CLEAR_B = 0 for 2 cycles, release -> TX_VALID = 0, SSPTXINTR = 0, TxData = 8'h00, TX_OVF = 0.
- Single word: push 8'hA5 -> next cycle TX_VALID = 1, TxData = 8'hA5; pulse NEXT_WORD -> TX_VALID = 0.
- Fill and order: push 8'h11, 8'h22, 8'h33, 8'h44 -> SSPTXINTR = 1 after the 4th edge. Pop 4 times -> TxData sequence 11, 22, 33, 44; SSPTXINTR drops after the first pop.
- Full with simultaneous push/pop: at full, same cycle push 8'h55 and NEXT_WORD -> count stays 4, SSPTXINTR stays 1; subsequent pops yield 22, 33, 44, 55. This run also exercises pointer wrap.
- Overflow (macro defined): at full, push 8'h99 with no pop -> word dropped, TX_OVF = 1. Pulse OVF_CLR -> TX_OVF = 0. Macro undefined -> TX_OVF stays 0.
- Async reset mid-operation: with 3 words queued, assert CLEAR_B between edges -> outputs go to reset values immediately without a clock edge. After release, pushing 8'h7E yields TxData = 8'h7E.
